// File: rtl/reg_block_pkg.sv
// Shared encodings for the register/stack block: GPR source selects and
// return-address push source selects.
package reg_block_pkg;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'b00,
        SRC_ALU  = 2'b01,
        SRC_IMM  = 2'b10,
        SRC_PEER = 2'b11
    } gpr_src_e;

    typedef enum logic {
        RA_SRC_MEM = 1'b0,
        RA_SRC_PC  = 1'b1
    } ra_src_e;

endpackage : reg_block_pkg

// File: rtl/reg_stack_block_ra_stack.sv
// Return-address stack: RA_DEPTH entries, modulo pointer, saturating count,
// sticky overflow/underflow flags. RA_WRAP selects drop-vs-overwrite on full.
module ra_stack #(
    parameter int WIDTH    = 16,
    parameter int RA_DEPTH = 8,
    parameter int RA_WRAP  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          clear_err,
    input  logic [WIDTH-1:0]              push_data,
    output logic [WIDTH-1:0]              top,
    output logic [$clog2(RA_DEPTH+1)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);
    import reg_block_pkg::*;

    localparam int CW = $clog2(RA_DEPTH + 1);
    localparam int PW = (RA_DEPTH > 1) ? $clog2(RA_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(RA_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RA_DEPTH);

    logic [WIDTH-1:0] mem [RA_DEPTH];
    // ptr is the next write slot; the top entry sits one below it (mod RA_DEPTH)
    logic [PW-1:0]    ptr, ptr_nxt, top_idx, wr_idx;
    logic [CW-1:0]    cnt_nxt;
    logic             do_write, ovf_evt, udf_evt, empty, full;

    assign empty   = (count == '0);
    assign full    = (count == FULL);
    assign top_idx = (ptr == '0) ? LAST : ptr - 1'b1;
    assign top     = empty ? '0 : mem[top_idx];

    // Next-state decode for pointer, count, memory write and error events
    always_comb begin
        do_write = 1'b0;
        wr_idx   = ptr;
        ptr_nxt  = ptr;
        cnt_nxt  = count;
        ovf_evt  = 1'b0;
        udf_evt  = 1'b0;
        if (push && pop && !empty) begin
            // replace top in place; push+pop on empty falls through to push
            do_write = 1'b1;
            wr_idx   = top_idx;
        end else if (push) begin
            if (!full) begin
                do_write = 1'b1;
                ptr_nxt  = (ptr == LAST) ? '0 : ptr + 1'b1;
                cnt_nxt  = count + 1'b1;
            end else if (RA_WRAP != 0) begin
                // when full, ptr points at the oldest entry
                do_write = 1'b1;
                ptr_nxt  = (ptr == LAST) ? '0 : ptr + 1'b1;
                ovf_evt  = 1'b1;
            end else begin
                ovf_evt  = 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                ptr_nxt = top_idx;
                cnt_nxt = count - 1'b1;
            end else begin
                udf_evt = 1'b1;
            end
        end
    end

    // Stack storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RA_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Pointer, count and sticky flags; a new event beats clear_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            count     <= cnt_nxt;
            overflow  <= ovf_evt | (overflow & ~clear_err);
            underflow <= udf_evt | (underflow & ~clear_err);
        end
    end

endmodule : ra_stack

// File: rtl/reg_stack_block.sv
// Register block: NUM_GPR general registers with per-register source mux,
// ALU comparison register, and a return-address stack for nested calls.
module reg_stack_block #(
    parameter int WIDTH    = 16,
    parameter int NUM_GPR  = 2,
    parameter int RA_DEPTH = 8,
    parameter int RA_WRAP  = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              memval,
    input  logic [WIDTH-1:0]              aluout,
    input  logic [WIDTH-1:0]              immediate,
    input  logic [WIDTH-1:0]              pc,
    input  logic [NUM_GPR-1:0]            gpr_write,
    input  logic [2*NUM_GPR-1:0]          gpr_src,
    output logic [WIDTH*NUM_GPR-1:0]      gpr_out,
    input  logic                          comp_write,
    output logic [WIDTH-1:0]              comp_out,
    input  logic                          ra_push,
    input  logic                          ra_pop,
    input  logic                          ra_src,
    input  logic                          ra_clear_err,
    output logic [WIDTH-1:0]              ra_out,
    output logic [$clog2(RA_DEPTH+1)-1:0] ra_count,
    output logic                          ra_overflow,
    output logic                          ra_underflow
);
    import reg_block_pkg::*;

    logic [WIDTH-1:0] ra_in;

    assign ra_in = (ra_src == RA_SRC_PC) ? pc : memval;

    for (genvar i = 0; i < NUM_GPR; i++) begin : g_gpr
        localparam int PEER = (i + 1) % NUM_GPR;

        logic [WIDTH-1:0] gpr_q, gpr_d;

        assign gpr_out[WIDTH*i +: WIDTH] = gpr_q;

        // Source mux; the peer path reads the pre-edge value, so mutual peer loads swap
        always_comb begin
            gpr_d = gpr_q;
            case (gpr_src[2*i +: 2])
                SRC_MEM:  gpr_d = memval;
                SRC_ALU:  gpr_d = aluout;
                SRC_IMM:  gpr_d = immediate;
                SRC_PEER: gpr_d = gpr_out[WIDTH*PEER +: WIDTH];
                default:  gpr_d = gpr_q;
            endcase
        end

        // Register load on write enable
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                gpr_q <= '0;
            end else if (gpr_write[i]) begin
                gpr_q <= gpr_d;
            end
        end
    end

    // comp register loads the ALU result on request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            comp_out <= '0;
        end else if (comp_write) begin
            comp_out <= aluout;
        end
    end

    ra_stack #(
        .WIDTH    (WIDTH),
        .RA_DEPTH (RA_DEPTH),
        .RA_WRAP  (RA_WRAP)
    ) u_ra_stack (
        .clk       (clock),
        .rst_n     (reset),
        .push      (ra_push),
        .pop       (ra_pop),
        .clear_err (ra_clear_err),
        .push_data (ra_in),
        .top       (ra_out),
        .count     (ra_count),
        .overflow  (ra_overflow),
        .underflow (ra_underflow)
    );

endmodule : reg_stack_block

// File: tb/tb_reg_stack_block.sv
// Directed bench: drop-mode (u_dut) and wrap-mode (u_wrap) instances share
// all inputs; each step checks against hand-computed values.
module tb_reg_stack_block;

    localparam int W  = 16;
    localparam int NG = 2;
    localparam int RD = 8;
    localparam int CW = $clog2(RD + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  memval = '0, aluout = '0, immediate = '0, pc = '0;
    logic [NG-1:0] gpr_write = '0;
    logic [2*NG-1:0] gpr_src = '0;
    logic          comp_write = 1'b0;
    logic          ra_push = 1'b0, ra_pop = 1'b0, ra_src = 1'b0, ra_clear_err = 1'b0;

    logic [W*NG-1:0] gpr_out0, gpr_out1;
    logic [W-1:0]    comp_out0, comp_out1, ra_out0, ra_out1;
    logic [CW-1:0]   ra_count0, ra_count1;
    logic            ovf0, ovf1, udf0, udf1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    reg_stack_block #(.WIDTH(W), .NUM_GPR(NG), .RA_DEPTH(RD), .RA_WRAP(0)) u_dut (
        .clock(clock), .reset(reset), .memval(memval), .aluout(aluout),
        .immediate(immediate), .pc(pc), .gpr_write(gpr_write), .gpr_src(gpr_src),
        .gpr_out(gpr_out0), .comp_write(comp_write), .comp_out(comp_out0),
        .ra_push(ra_push), .ra_pop(ra_pop), .ra_src(ra_src), .ra_clear_err(ra_clear_err),
        .ra_out(ra_out0), .ra_count(ra_count0), .ra_overflow(ovf0), .ra_underflow(udf0)
    );

    reg_stack_block #(.WIDTH(W), .NUM_GPR(NG), .RA_DEPTH(RD), .RA_WRAP(1)) u_wrap (
        .clock(clock), .reset(reset), .memval(memval), .aluout(aluout),
        .immediate(immediate), .pc(pc), .gpr_write(gpr_write), .gpr_src(gpr_src),
        .gpr_out(gpr_out1), .comp_write(comp_write), .comp_out(comp_out1),
        .ra_push(ra_push), .ra_pop(ra_pop), .ra_src(ra_src), .ra_clear_err(ra_clear_err),
        .ra_out(ra_out1), .ra_count(ra_count1), .ra_overflow(ovf1), .ra_underflow(udf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock, then sample 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ra_idle();
        ra_push = 1'b0; ra_pop = 1'b0; ra_clear_err = 1'b0;
    endtask

    task automatic check_stacks(input string tag, input logic [W-1:0] o0, input int c0,
                                input logic [W-1:0] o1, input int c1);
        check({tag, " ra_out0"},   32'(ra_out0),   32'(o0));
        check({tag, " ra_count0"}, 32'(ra_count0), c0);
        check({tag, " ra_out1"},   32'(ra_out1),   32'(o1));
        check({tag, " ra_count1"}, 32'(ra_count1), c1);
    endtask

    initial begin
        // ---- reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst gpr_out", 32'(gpr_out0), 0);
        check("rst comp", 32'(comp_out0), 0);
        check_stacks("rst", 16'h0, 0, 16'h0, 0);
        check("rst flags", {ovf0, udf0, ovf1, udf1}, 0);
        reset = 1'b1;
        tick();

        // ---- GPR load, swap, hold
        gpr_write = 2'b11; gpr_src = 4'b0010; immediate = 16'h1234; memval = 16'hABCD;
        tick();
        check("gpr0 imm", 32'(gpr_out0[15:0]), 32'h1234);
        check("gpr1 mem", 32'(gpr_out0[31:16]), 32'hABCD);
        gpr_src = 4'b1111;
        tick();
        check("swap gpr0", 32'(gpr_out0[15:0]), 32'hABCD);
        check("swap gpr1", 32'(gpr_out0[31:16]), 32'h1234);
        gpr_write = 2'b00; gpr_src = 4'b0101; memval = 16'h1111; aluout = 16'h2222; immediate = 16'h3333;
        tick();
        tick();
        check("hold gprs", 32'(gpr_out0), 32'h1234ABCD);
        gpr_write = 2'b01; gpr_src = 4'b0001; aluout = 16'h5A5A;
        tick();
        check("gpr0 alu", 32'(gpr_out0), 32'h12345A5A);
        gpr_write = 2'b00;
        comp_write = 1'b1; aluout = 16'hBEEF;
        tick();
        check("comp load", 32'(comp_out0), 32'hBEEF);
        comp_write = 1'b0; aluout = 16'h0F0F;
        tick();
        check("comp hold", 32'(comp_out0), 32'hBEEF);

        // ---- nested calls
        ra_src = 1'b1;
        ra_push = 1'b1;
        pc = 16'h0010; tick();
        pc = 16'h0020; tick();
        pc = 16'h0030; tick();
        ra_idle();
        check_stacks("push3", 16'h0030, 3, 16'h0030, 3);
        ra_pop = 1'b1;
        tick(); check_stacks("pop1", 16'h0020, 2, 16'h0020, 2);
        tick(); check_stacks("pop2", 16'h0010, 1, 16'h0010, 1);
        tick(); check_stacks("pop3", 16'h0000, 0, 16'h0000, 0);
        ra_idle();
        check("nest flags", {ovf0, udf0, ovf1, udf1}, 0);

        // ---- simultaneous push+pop
        ra_push = 1'b1;
        pc = 16'h0010; tick();
        pc = 16'h0020; tick();
        ra_src = 1'b0; memval = 16'h00FF; ra_pop = 1'b1;
        tick();
        ra_idle();
        check_stacks("pp full", 16'h00FF, 2, 16'h00FF, 2);
        ra_pop = 1'b1;
        tick(); tick();
        ra_push = 1'b1;
        tick();
        ra_idle();
        check_stacks("pp empty", 16'h00FF, 1, 16'h00FF, 1);
        check("pp empty udf", {udf0, udf1}, 0);
        ra_pop = 1'b1;
        tick();
        ra_idle();

        // ---- asynchronous reset mid-sequence with a push pending
        ra_push = 1'b1; memval = 16'h0077;
        tick();
        check("pre-rst count", 32'(ra_count0), 1);
        #2 reset = 1'b0;
        #1;
        check("async gpr", 32'(gpr_out0), 0);
        check("async comp", 32'(comp_out0), 0);
        check_stacks("async", 16'h0, 0, 16'h0, 0);
        tick();
        check_stacks("rst held", 16'h0, 0, 16'h0, 0);
        ra_idle();
        reset = 1'b1;
        tick();
        check_stacks("post rst", 16'h0, 0, 16'h0, 0);

        // ---- overflow: push 1..9
        ra_src = 1'b0; ra_push = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            memval = W'(i);
            tick();
        end
        check("full no ovf", {ovf0, ovf1}, 0);
        memval = 16'd9;
        tick();
        ra_idle();
        check_stacks("ovf", 16'd8, 8, 16'd9, 8);
        check("ovf flags", {ovf0, ovf1}, 2'b11);
        ra_clear_err = 1'b1;
        tick();
        ra_idle();
        check("clr ovf", {ovf0, ovf1}, 0);

        // ---- eight pops: drop mode returns 8..1, wrap mode 9..2
        for (int k = 1; k <= 8; k++) begin
            check("pop seq0", 32'(ra_out0), 32'(9 - k));
            check("pop seq1", 32'(ra_out1), 32'(10 - k));
            ra_pop = 1'b1;
            tick();
        end
        ra_idle();
        check_stacks("drained", 16'h0, 0, 16'h0, 0);
        check("drained udf", {udf0, udf1}, 0);
        ra_pop = 1'b1;
        tick();
        ra_idle();
        check("underflow", {udf0, udf1}, 2'b11);
        check_stacks("udf", 16'h0, 0, 16'h0, 0);
        // new underflow event in the same cycle as clear keeps the flag set
        ra_pop = 1'b1; ra_clear_err = 1'b1;
        tick();
        ra_idle();
        check("udf beats clr", {udf0, udf1}, 2'b11);
        ra_clear_err = 1'b1;
        tick();
        ra_idle();
        check("udf cleared", {udf0, udf1}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_stack_block
